// File: rtl/conv_pkg.sv
// Shared types and defaults for the conv block sequencers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package conv_pkg;

    // Default chain length (PEs per column)
    localparam int KSIZE_DEFAULT = 3;

    // Sequencer states of the PE column controller
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_DONE    = 3'd4
    } conv_state_t;

    // True while the sequencer owns the PE column
    function automatic logic state_busy(input conv_state_t st);
        return st != ST_IDLE;
    endfunction

endpackage

// File: rtl/pe_valid_pipe.sv
// Valid tracker mirroring the PE chain: one bit per stage plus a consumed flag.
// Latency: a sum is flagged KSIZE advances after its pixel enters the chain.
// Backpressure: the head sum stays presented until out_ready; 'taken' hides it while the chain holds.
module pe_valid_pipe #(
    parameter int KSIZE = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic advance,
    input  logic shift_in,
    input  logic out_ready,
    output logic out_valid,
    output logic pipe_empty
);

    logic [KSIZE-1:0] vld;
    logic [KSIZE-1:0] vld_next;
    logic             taken;

    // Next value of the tracker when the chain advances
    generate
        if (KSIZE == 1) begin : g_single
            assign vld_next = shift_in;
        end else begin : g_multi
            assign vld_next = {vld[KSIZE-2:0], shift_in};
        end
    endgenerate

    // Shift the valid bits in lock-step with the PE registers
    always_ff @(posedge clk) begin
        if (rst) begin
            vld <= '0;
        end else if (advance) begin
            vld <= vld_next;
        end
    end

    // Remember a sum consumed while the chain is held so it is not shown twice
    always_ff @(posedge clk) begin
        if (rst) begin
            taken <= 1'b0;
        end else if (advance) begin
            taken <= 1'b0;
        end else if (out_valid && out_ready) begin
            taken <= 1'b1;
        end
    end

    assign out_valid  = vld[KSIZE-1] & ~taken;
    assign pipe_empty = ~|vld;

endmodule

// File: rtl/pe_chain_ctrl.sv
// Sequencer for one KSIZE-long MAC PE column: weight load, pixel stream, drain, done pulse.
// Latency: first sum valid KSIZE advances after the first pixel accept; done one cycle after drain empties.
// Backpressure: out_valid & ~out_ready freezes the whole chain (no advance, ifm_ready low).
module pe_chain_ctrl
    import conv_pkg::*;
#(
    parameter int KSIZE = KSIZE_DEFAULT,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] cfg_num_pix,
    output logic             busy,
    output logic             done,
    input  logic             wgt_valid,
    output logic             wgt_ready,
    output logic [KSIZE-1:0] wgt_we,
    input  logic             ifm_valid,
    output logic             ifm_ready,
    output logic             pe_set_reg,
    output logic             pe_ifm_zero,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] pix_cnt
);

    localparam int WIDX_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    conv_state_t       state;
    conv_state_t       state_nxt;
    logic [CNT_W-1:0]  num_pix_q;
    logic [WIDX_W-1:0] widx;

    logic start_acc;
    logic wgt_acc;
    logic pix_acc;
    logic last_wgt;
    logic last_pix;
    logic stall;
    logic shift_in;
    logic pipe_empty;

    assign last_wgt = (widx == WIDX_W'(KSIZE - 1));
    assign last_pix = ((pix_cnt + CNT_W'(1)) == num_pix_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshakes and chain controls
    always_comb begin
        state_nxt   = state;
        busy        = state_busy(state);
        done        = 1'b0;
        wgt_ready   = 1'b0;
        wgt_we      = '0;
        ifm_ready   = 1'b0;
        pe_set_reg  = 1'b0;
        pe_ifm_zero = 1'b0;
        shift_in    = 1'b0;
        start_acc   = 1'b0;
        wgt_acc     = 1'b0;
        pix_acc     = 1'b0;
        stall       = out_valid & ~out_ready;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    state_nxt = ST_LOAD;
                end
            end
            ST_LOAD: begin
                wgt_ready = 1'b1;
                if (wgt_valid) begin
                    wgt_acc = 1'b1;
                    wgt_we  = KSIZE'(1) << widx;
                    if (last_wgt) begin
                        state_nxt = (num_pix_q == '0) ? ST_DONE : ST_COMPUTE;
                    end
                end
            end
            ST_COMPUTE: begin
                ifm_ready  = ~stall;
                shift_in   = 1'b1;
                pe_set_reg = ifm_valid & ~stall;
                pix_acc    = ifm_valid & ~stall;
                if (pix_acc && last_pix) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                pe_ifm_zero = 1'b1;
                pe_set_reg  = ~stall;
                if (pipe_empty) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Job count capture, weight index and accepted-pixel counter
    always_ff @(posedge clk) begin
        if (rst) begin
            num_pix_q <= '0;
            widx      <= '0;
            pix_cnt   <= '0;
        end else begin
            if (start_acc) begin
                num_pix_q <= cfg_num_pix;
                widx      <= '0;
                pix_cnt   <= '0;
            end
            if (wgt_acc) begin
                widx <= last_wgt ? '0 : widx + WIDX_W'(1);
            end
            if (pix_acc && (pix_cnt != num_pix_q)) begin
                pix_cnt <= pix_cnt + CNT_W'(1);
            end
        end
    end

    pe_valid_pipe #(
        .KSIZE (KSIZE)
    ) u_valid_pipe (
        .clk        (clk),
        .rst        (rst),
        .advance    (pe_set_reg),
        .shift_in   (shift_in),
        .out_ready  (out_ready),
        .out_valid  (out_valid),
        .pipe_empty (pipe_empty)
    );

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Randomized bench for pe_chain_ctrl against a pixel-age reference model.
// Latency: model predicts every output each cycle, sampled mid-cycle.
// Backpressure: out_ready holds and random valids exercise stall/taken paths.
module tb_pe_chain_ctrl;

    localparam int KSIZE = 3;
    localparam int CNT_W = 16;

    localparam int P_IDLE  = 0;
    localparam int P_LOAD  = 1;
    localparam int P_COMP  = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] cfg_num_pix;
    logic             busy;
    logic             done;
    logic             wgt_valid;
    logic             wgt_ready;
    logic [KSIZE-1:0] wgt_we;
    logic             ifm_valid;
    logic             ifm_ready;
    logic             pe_set_reg;
    logic             pe_ifm_zero;
    logic             out_valid;
    logic             out_ready;
    logic [CNT_W-1:0] pix_cnt;

    always #5 clk = ~clk;

    pe_chain_ctrl #(
        .KSIZE (KSIZE),
        .CNT_W (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cfg_num_pix (cfg_num_pix),
        .busy        (busy),
        .done        (done),
        .wgt_valid   (wgt_valid),
        .wgt_ready   (wgt_ready),
        .wgt_we      (wgt_we),
        .ifm_valid   (ifm_valid),
        .ifm_ready   (ifm_ready),
        .pe_set_reg  (pe_set_reg),
        .pe_ifm_zero (pe_ifm_zero),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .pix_cnt     (pix_cnt)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: job phase, counts, and the age (advances seen) of each in-flight pixel
    int m_ph;
    int m_npix;
    int m_wcnt;
    int m_acc;
    bit m_head_taken;
    int ages[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit rnd(input int p);
        return int'($urandom_range(0, 99)) < p;
    endfunction

    // A finished sum is visible when the oldest pixel has seen KSIZE advances and was not yet taken
    function automatic bit m_ov();
        return (ages.size() > 0) && (ages[0] == KSIZE) && !m_head_taken;
    endfunction

    function automatic bit m_stall();
        return m_ov() && !out_ready;
    endfunction

    function automatic bit m_set();
        return ((m_ph == P_COMP && ifm_valid) || m_ph == P_DRAIN) && !m_stall();
    endfunction

    task automatic m_reset();
        m_ph = P_IDLE;
        m_npix = 0;
        m_wcnt = 0;
        m_acc = 0;
        m_head_taken = 1'b0;
        ages.delete();
    endtask

    task automatic m_update();
        bit ov;
        bit set;
        bit was_empty;
        ov = m_ov();
        set = m_set();
        was_empty = (ages.size() == 0);
        if (rst) begin
            m_reset();
            return;
        end
        if (set) begin
            foreach (ages[i]) ages[i] = ages[i] + 1;
            if (ages.size() > 0 && ages[0] > KSIZE) void'(ages.pop_front());
            if (m_ph == P_COMP) ages.push_back(1);
            m_head_taken = 1'b0;
        end else if (ov && out_ready) begin
            m_head_taken = 1'b1;
        end
        case (m_ph)
            P_IDLE: if (start) begin
                m_ph = P_LOAD;
                m_npix = int'(cfg_num_pix);
                m_wcnt = 0;
                m_acc = 0;
            end
            P_LOAD: if (wgt_valid) begin
                m_wcnt++;
                if (m_wcnt == KSIZE) m_ph = (m_npix == 0) ? P_DONE : P_COMP;
            end
            P_COMP: if (set) begin
                m_acc++;
                if (m_acc == m_npix) m_ph = P_DRAIN;
            end
            P_DRAIN: if (was_empty) m_ph = P_DONE;
            default: m_ph = P_IDLE;
        endcase
    endtask

    // One clock: inputs already driven just after the edge; check at mid-cycle, then advance
    task automatic step();
        logic [31:0] exp_we;
        #4;
        exp_we = (m_ph == P_LOAD && wgt_valid) ? (32'd1 << m_wcnt) : 32'd0;
        chk("busy",        busy,        m_ph != P_IDLE);
        chk("done",        done,        m_ph == P_DONE);
        chk("wgt_ready",   wgt_ready,   m_ph == P_LOAD);
        chk("wgt_we",      wgt_we,      exp_we);
        chk("ifm_ready",   ifm_ready,   m_ph == P_COMP && !m_stall());
        chk("pe_set_reg",  pe_set_reg,  m_set());
        chk("pe_ifm_zero", pe_ifm_zero, m_ph == P_DRAIN);
        chk("out_valid",   out_valid,   m_ov());
        chk("pix_cnt",     pix_cnt,     m_acc);
        m_update();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_step();
        rst = 1'b0;
        start = 1'b0;
        cfg_num_pix = CNT_W'($urandom_range(0, 9));
        wgt_valid = rnd(50);
        ifm_valid = rnd(50);
        out_ready = rnd(50);
        step();
    endtask

    task automatic run_job(input int npix, input int p_wv, input int p_iv, input int p_or,
                           input int hold_n, input bit toggle, input int rst_at, input bit spam);
        int budget;
        int hold_left;
        bit seen;
        bit iv_t;
        budget = 0;
        hold_left = 0;
        seen = 1'b0;
        iv_t = 1'b1;
        rst = 1'b0;
        start = 1'b1;
        cfg_num_pix = CNT_W'(npix);
        wgt_valid = rnd(p_wv);
        ifm_valid = rnd(p_iv);
        out_ready = rnd(p_or);
        step();
        while (m_ph != P_IDLE && budget < 2000) begin
            budget++;
            start = spam;
            if (spam) cfg_num_pix = CNT_W'($urandom_range(0, 9));
            wgt_valid = rnd(p_wv);
            ifm_valid = toggle ? iv_t : rnd(p_iv);
            iv_t = ~iv_t;
            if (hold_n > 0 && !seen && m_ov()) begin
                seen = 1'b1;
                hold_left = hold_n;
            end
            if (hold_left > 0) begin
                out_ready = 1'b0;
                hold_left--;
            end else begin
                out_ready = rnd(p_or);
            end
            rst = (rst_at >= 0 && m_ph == P_COMP && m_acc == rst_at);
            step();
        end
        rst = 1'b0;
        start = 1'b0;
        if (budget >= 2000) chk("job_timeout", budget, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_num_pix = '0;
        wgt_valid = 1'b0;
        ifm_valid = 1'b0;
        out_ready = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        step();
        rst = 1'b0;
        repeat (3) idle_step();

        run_job(4, 100, 100, 100, 0, 1'b0, -1, 1'b0);
        idle_step();
        run_job(4, 100, 100, 100, 5, 1'b0, -1, 1'b0);
        idle_step();
        run_job(4, 100, 100, 100, 0, 1'b1, -1, 1'b0);
        idle_step();
        run_job(0, 100, 100, 100, 0, 1'b0, -1, 1'b0);
        idle_step();
        run_job(5, 100, 100, 100, 0, 1'b0, 2, 1'b0);
        idle_step();
        run_job(2, 100, 100, 100, 0, 1'b0, -1, 1'b0);
        idle_step();
        run_job(3, 100, 100, 100, 0, 1'b0, -1, 1'b1);
        idle_step();

        for (int j = 0; j < 40; j++) begin
            run_job($urandom_range(0, 7),
                    $urandom_range(30, 100),
                    $urandom_range(20, 100),
                    $urandom_range(20, 100),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 6)) : 0,
                    $urandom_range(0, 4) == 0,
                    ($urandom_range(0, 5) == 0) ? int'($urandom_range(0, 3)) : -1,
                    $urandom_range(0, 3) == 0);
            if ($urandom_range(0, 1) == 1) idle_step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
